// File: rtl/flex_down_counter.sv
// rtl/flex_down_counter.sv - loadable down-counter/timer with start/busy/done handshake and auto-reload
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 5
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done,
  output logic                    zero_flag
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    load_nonzero;

  assign load_nonzero = (load_val != CNT_ZERO);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (load_nonzero) begin
              count_d = load_val;
              state_d = RUN;
            end else begin
              // Zero-length timer: report completion without ever entering RUN.
              count_d = CNT_ZERO;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (count_enable) begin
            if (count_q == CNT_ONE) begin
              done_d = 1'b1;
              // Reload skips zero so the period is exactly load_val enabled cycles.
              if (auto_reload && load_nonzero) begin
                count_d = load_val;
              end else begin
                count_d = CNT_ZERO;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      count_q <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign zero_flag = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_flex_down_counter.sv
// tb/tb_flex_down_counter.sv - directed self-checking bench for flex_down_counter
module tb_flex_down_counter;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       start;
  logic       count_enable;
  logic       auto_reload;
  logic [7:0] load_val;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic       zero_flag;

  int total;
  int bad;

  flex_down_counter #(.NUM_CNT_BITS(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .start        (start),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .load_val     (load_val),
    .count_out    (count_out),
    .busy         (busy),
    .done         (done),
    .zero_flag    (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; start = 1'b0; count_enable = 1'b0;
    auto_reload = 1'b0; load_val = 8'd0;
    tick();
    total++;
    if ({count_out, busy, done, zero_flag} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got cnt=%0d busy=%b done=%b zero=%b want 0/0/0/1", count_out, busy, done, zero_flag);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] ec;
    load_val = 8'd5; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      ec = (i >= 5) ? 8'd0 : 8'(5 - i);
      total++;
      if ({count_out, busy, done, zero_flag} !== {ec, (i < 5), (i == 5), (i >= 5)}) begin
        bad++;
        $display("FAIL basic[%0d]: got cnt=%0d busy=%b done=%b zero=%b want cnt=%0d busy=%b done=%b zero=%b",
                 i, count_out, busy, done, zero_flag, ec, (i < 5), (i == 5), (i >= 5));
      end
      tick();
    end
  endtask

  task automatic test_auto_reload();
    int seq [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    load_val = 8'd3; auto_reload = 1'b1; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({count_out, busy, done} !== {8'(seq[i]), 1'b1, (i == 3 || i == 6 || i == 9)}) begin
        bad++;
        $display("FAIL reload[%0d]: got cnt=%0d busy=%b done=%b want cnt=%0d busy=1 done=%b",
                 i, count_out, busy, done, seq[i], (i == 3 || i == 6 || i == 9));
      end
      if (i < 9) tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({count_out, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reload_clear: got cnt=%0d busy=%b done=%b want 0/0/0", count_out, busy, done);
    end
    // load_val = 1 makes every enabled cycle terminal; then load_val = 0 at terminal stops.
    load_val = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({count_out, busy, done} !== {8'd1, 1'b1, (i > 0)}) begin
        bad++;
        $display("FAIL reload1[%0d]: got cnt=%0d busy=%b done=%b want cnt=1 busy=1 done=%b",
                 i, count_out, busy, done, (i > 0));
      end
      tick();
    end
    // the final tick above reloaded once more; now drop load_val to zero
    load_val = 8'd0;
    tick();
    total++;
    if ({count_out, busy, done} !== {8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reload0: got cnt=%0d busy=%b done=%b want 0/0/1", count_out, busy, done);
    end
    auto_reload = 1'b0;
    tick();
  endtask

  task automatic test_gap();
    int seq [8] = '{4, 3, 2, 2, 2, 2, 1, 0};
    load_val = 8'd4; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        count_enable = !(k >= 3 && k <= 5);
        tick();
      end
      total++;
      if ({count_out, busy, done} !== {8'(seq[k]), (k < 7), (k == 7)}) begin
        bad++;
        $display("FAIL gap[%0d]: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 k, count_out, busy, done, seq[k], (k < 7), (k == 7));
      end
    end
    count_enable = 1'b1;
    tick();
  endtask

  task automatic test_zero_len();
    load_val = 8'd0; start = 1'b1;
    tick();
    total++;
    if ({count_out, busy, done, zero_flag} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL zero_len: got cnt=%0d busy=%b done=%b zero=%b want 0/0/1/1", count_out, busy, done, zero_flag);
    end
    tick();
    total++;
    if ({busy, done} !== {1'b0, 1'b1}) begin
      bad++;
      $display("FAIL zero_b2b: got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    start = 1'b0;
    tick();
    total++;
    if ({count_out, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL zero_after: got cnt=%0d busy=%b done=%b want 0/0/0", count_out, busy, done);
    end
  endtask

  task automatic test_start_ignored();
    int seq [5] = '{4, 3, 2, 1, 0};
    load_val = 8'd4; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        start    = (k == 3);
        load_val = (k == 3) ? 8'd9 : 8'd4;
        tick();
      end
      total++;
      if ({count_out, busy, done} !== {8'(seq[k]), (k < 4), (k == 4)}) begin
        bad++;
        $display("FAIL restart[%0d]: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 k, count_out, busy, done, seq[k], (k < 4), (k == 4));
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    load_val = 8'd2; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if ({count_out, busy} !== {8'd1, 1'b1}) begin
      bad++;
      $display("FAIL clear_pre: got cnt=%0d busy=%b want cnt=1 busy=1", count_out, busy);
    end
    clear = 1'b1;
    tick();
    total++;
    if ({count_out, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL clear_term: got cnt=%0d busy=%b done=%b want 0/0/0", count_out, busy, done);
    end
    load_val = 8'd5; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    total++;
    if ({count_out, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL clear_start: got cnt=%0d busy=%b done=%b want 0/0/0", count_out, busy, done);
    end
  endtask

  task automatic test_async_reset();
    load_val = 8'd200; count_enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 193; i++) tick();
    total++;
    if (count_out !== 8'd7) begin
      bad++;
      $display("FAIL arst_pre: got cnt=%0d want 7", count_out);
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({count_out, busy, done, zero_flag} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL arst_now: got cnt=%0d busy=%b done=%b zero=%b want 0/0/0/1", count_out, busy, done, zero_flag);
    end
    @(negedge clk);
    n_rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({count_out, busy} !== {8'd200, 1'b1}) begin
      bad++;
      $display("FAIL arst_start: got cnt=%0d busy=%b want cnt=200 busy=1", count_out, busy);
    end
    for (int i = 1; i <= 200; i++) begin
      tick();
      total++;
      if ({count_out, busy, done} !== {8'(200 - i), (i < 200), (i == 200)}) begin
        bad++;
        $display("FAIL arst_run[%0d]: got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                 i, count_out, busy, done, 200 - i, (i < 200), (i == 200));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_auto_reload();
    test_gap();
    test_zero_len();
    test_start_ignored();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
